// File: rtl/act_fetch_resp.sv
// Activation fetch responder: turns fetch-request pulses into SRAM ring-buffer reads and returns
// one registered word per request as a GetAct pulse. Reads never overtake the DMA writer, and the
// layer finishes with FnhLay once the configured number of words has been returned.
module act_fetch_resp #(
  parameter int unsigned ACT_WIDTH  = 64,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned TOT_WIDTH  = 20,
  parameter int unsigned PEND_MAX   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  TOP_Sta,
  input  logic [ADDR_WIDTH-1:0] CFG_BaseAddr,
  input  logic [ADDR_WIDTH-1:0] CFG_BufWord,
  input  logic [TOT_WIDTH-1:0]  CFG_TotWord,
  input  logic                  PlsFetch,
  output logic                  GetAct,
  output logic [ACT_WIDTH-1:0]  ActData,
  output logic                  SRAM_RdEn,
  output logic [ADDR_WIDTH-1:0] SRAM_RdAddr,
  input  logic [ACT_WIDTH-1:0]  SRAM_RdData,
  input  logic                  DMA_WrWord,
  output logic                  Busy,
  output logic                  FnhLay,
  output logic                  Err_Ovf
);

  localparam int unsigned PendW  = $clog2(PEND_MAX + 1);
  localparam int unsigned AvailW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [PendW-1:0]      pend_cnt_q, pend_cnt_d;
  logic [AvailW-1:0]     avail_cnt_q, avail_cnt_d;
  logic [TOT_WIDTH-1:0]  iss_cnt_q, iss_cnt_d;
  logic                  err_ovf_q, err_ovf_d;

  // Two-stage return pipe: read-enable stage, then registered data stage.
  logic                  rd_vld_q, rd_last_q;
  logic                  get_act_q, get_last_q;
  logic [ACT_WIDTH-1:0]  act_data_q;

  logic                  issue, issue_last, fetch_cnt, pend_full, avail_full, last_ret;
  logic [ADDR_WIDTH-1:0] ring_end;
  logic [AvailW-1:0]     ring_size;

  assign issue      = (state_q == StRun) && (pend_cnt_q != '0) && (avail_cnt_q != '0);
  assign issue_last = issue && (iss_cnt_q == CFG_TotWord);
  // Requests only count while reads can still be issued; DRAIN and IDLE drop them.
  assign fetch_cnt  = PlsFetch && (state_q == StRun);
  assign ring_end   = CFG_BaseAddr + CFG_BufWord;
  assign ring_size  = {1'b0, CFG_BufWord} + AvailW'(1);
  assign pend_full  = (pend_cnt_q == PendW'(PEND_MAX));
  assign avail_full = (avail_cnt_q == ring_size);
  assign last_ret   = get_act_q && get_last_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: TOP_Sta always (re)starts a layer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (TOP_Sta) state_d = StRun;
      StRun: begin
        if (TOP_Sta)         state_d = StRun;
        else if (issue_last) state_d = StDrain;
      end
      StDrain: begin
        if (TOP_Sta)       state_d = StRun;
        else if (last_ret) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from registers only.
  always_comb begin
    SRAM_RdEn   = issue;
    SRAM_RdAddr = issue ? rd_ptr_q : '0;
    GetAct      = get_act_q;
    ActData     = act_data_q;
    Busy        = (state_q != StIdle);
    FnhLay      = last_ret;
    Err_Ovf     = err_ovf_q;
  end

  // Counter and pointer next-state; saturating counters flag overflow instead of wrapping.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    pend_cnt_d  = pend_cnt_q;
    avail_cnt_d = avail_cnt_q;
    iss_cnt_d   = iss_cnt_q;
    err_ovf_d   = err_ovf_q;
    if (TOP_Sta) begin
      rd_ptr_d    = CFG_BaseAddr;
      pend_cnt_d  = PlsFetch ? PendW'(1) : '0;
      avail_cnt_d = '0;
      iss_cnt_d   = '0;
      err_ovf_d   = 1'b0;
    end else begin
      if (issue) begin
        rd_ptr_d  = (rd_ptr_q == ring_end) ? CFG_BaseAddr : rd_ptr_q + ADDR_WIDTH'(1);
        iss_cnt_d = iss_cnt_q + TOT_WIDTH'(1);
      end
      if (fetch_cnt && !issue) begin
        if (pend_full) err_ovf_d = 1'b1;
        else           pend_cnt_d = pend_cnt_q + PendW'(1);
      end else if (issue && !fetch_cnt) begin
        pend_cnt_d = pend_cnt_q - PendW'(1);
      end
      if (DMA_WrWord && !issue) begin
        if (avail_full) err_ovf_d = 1'b1;
        else            avail_cnt_d = avail_cnt_q + AvailW'(1);
      end else if (issue && !DMA_WrWord) begin
        avail_cnt_d = avail_cnt_q - AvailW'(1);
      end
    end
  end

  // Counter and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      pend_cnt_q  <= '0;
      avail_cnt_q <= '0;
      iss_cnt_q   <= '0;
      err_ovf_q   <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      pend_cnt_q  <= pend_cnt_d;
      avail_cnt_q <= avail_cnt_d;
      iss_cnt_q   <= iss_cnt_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  // Return pipe; a restart kills both in-flight stages so stale words never reach GetAct.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q   <= 1'b0;
      rd_last_q  <= 1'b0;
      get_act_q  <= 1'b0;
      get_last_q <= 1'b0;
      act_data_q <= '0;
    end else begin
      rd_vld_q   <= issue && !TOP_Sta;
      rd_last_q  <= issue_last;
      get_act_q  <= rd_vld_q && !TOP_Sta;
      get_last_q <= rd_last_q;
      if (rd_vld_q && !TOP_Sta) act_data_q <= SRAM_RdData;
    end
  end

endmodule

// File: tb/tb_act_fetch_resp.sv
// Bench for act_fetch_resp: directed scenarios plus randomized layers, checked by a monitor that
// keeps a counter-level model of requests/available words and a scoreboard of expected returns.
module tb_act_fetch_resp;

  localparam int PEND_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        top_sta, pls_drv, echo_en, dma_wr;
  logic [9:0]  cfg_base, cfg_buf;
  logic [19:0] cfg_tot;
  logic        pls_fetch;
  logic        get_act, sram_rd_en, busy, fnh_lay, err_ovf;
  logic [63:0] act_data, sram_rd_data;
  logic [9:0]  sram_rd_addr;

  always #5 clk = ~clk;

  // Consumer that may re-request combinationally on every returned word.
  assign pls_fetch = pls_drv | (echo_en & get_act);

  act_fetch_resp #(
    .ACT_WIDTH(64), .ADDR_WIDTH(10), .TOT_WIDTH(20), .PEND_MAX(PEND_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .TOP_Sta(top_sta), .CFG_BaseAddr(cfg_base),
    .CFG_BufWord(cfg_buf), .CFG_TotWord(cfg_tot), .PlsFetch(pls_fetch), .GetAct(get_act),
    .ActData(act_data), .SRAM_RdEn(sram_rd_en), .SRAM_RdAddr(sram_rd_addr),
    .SRAM_RdData(sram_rd_data), .DMA_WrWord(dma_wr), .Busy(busy), .FnhLay(fnh_lay),
    .Err_Ovf(err_ovf)
  );

  // SRAM with one-cycle read latency.
  logic [63:0] mem [1024];
  always @(posedge clk) if (sram_rd_en) sram_rd_data <= mem[sram_rd_addr];

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  // Reference model: layer phase, outstanding requests, readable words, words issued.
  typedef struct {
    int unsigned due;
    logic [63:0] data;
    bit          last;
  } ret_t;
  ret_t ret_q[$];
  ret_t ent;
  int   phase;  // 0 idle, 1 issuing, 2 waiting for final return
  int   pend_m, avail_m, iss_m, ring;
  bit   err_m, exp_rd, exp_get, exp_last, inc_p;
  logic [9:0] exp_addr;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_get_act", get_act, 0);
      chk("rst_act_data", act_data, 0);
      chk("rst_rd_en", sram_rd_en, 0);
      chk("rst_rd_addr", sram_rd_addr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fnh_lay", fnh_lay, 0);
      chk("rst_err_ovf", err_ovf, 0);
      phase = 0; pend_m = 0; avail_m = 0; iss_m = 0; err_m = 0; cyc = 0;
      ret_q.delete();
    end else begin
      cyc++;
      ring   = int'(cfg_buf) + 1;
      exp_rd = (phase == 1) && (pend_m > 0) && (avail_m > 0);
      chk("rd_en", sram_rd_en, exp_rd);
      if (exp_rd) begin
        exp_addr = 10'(int'(cfg_base) + (iss_m % ring));
        chk("rd_addr", sram_rd_addr, exp_addr);
        ent.due  = cyc + 2;
        ent.data = mem[exp_addr];
        ent.last = (iss_m == int'(cfg_tot));
        ret_q.push_back(ent);
      end
      exp_get  = (ret_q.size() > 0) && (ret_q[0].due == cyc);
      exp_last = exp_get && ret_q[0].last;
      chk("get_act", get_act, exp_get);
      chk("fnh_lay", fnh_lay, exp_last);
      if (exp_get) begin
        chk("act_data", act_data, ret_q[0].data);
        void'(ret_q.pop_front());
      end
      chk("busy", busy, phase != 0);
      chk("err_ovf", err_ovf, err_m);
      if (top_sta) begin
        ret_q.delete();
        phase = 1; iss_m = 0; avail_m = 0; err_m = 0;
        pend_m = pls_fetch ? 1 : 0;
      end else begin
        inc_p = pls_fetch && (phase == 1);
        if (exp_rd) iss_m++;
        if (inc_p && !exp_rd) begin
          if (pend_m == PEND_MAX) err_m = 1; else pend_m++;
        end else if (exp_rd && !inc_p) begin
          pend_m--;
        end
        if (dma_wr && !exp_rd) begin
          if (avail_m == ring) err_m = 1; else avail_m++;
        end else if (exp_rd && !dma_wr) begin
          avail_m--;
        end
        if (exp_rd && iss_m == int'(cfg_tot) + 1) phase = 2;
        else if (phase == 2 && exp_last)         phase = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_layer(input logic [9:0] base, input logic [9:0] bufw,
                             input logic [19:0] tot, input bit fetch);
    cfg_base = base; cfg_buf = bufw; cfg_tot = tot;
    top_sta = 1'b1; pls_drv = fetch; dma_wr = 1'b0;
    tick(1);
    top_sta = 1'b0; pls_drv = 1'b0;
  endtask

  // Run until Busy drops; optionally keep feeding requests and words so the layer can finish.
  task automatic wait_done(input int limit, input bit feed);
    int n = 0;
    while (busy && n < limit) begin
      pls_drv = feed && (n % 3 == 0);
      dma_wr  = feed && (n % 2 == 0);
      tick(1);
      n++;
    end
    pls_drv = 1'b0; dma_wr = 1'b0;
    tick(1);
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL layer_done: busy got 1 after %0d cycles, expected 0", limit);
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};
    sram_rd_data = '0;
    top_sta = 0; pls_drv = 0; echo_en = 0; dma_wr = 0;
    cfg_base = '0; cfg_buf = '0; cfg_tot = '0;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Basic return with echoed requests.
    start_layer(10'h010, 10'd7, 20'd3, 1'b1);
    echo_en = 1'b1;
    dma_wr = 1'b1; tick(8); dma_wr = 1'b0;
    wait_done(100, 1'b0);
    echo_en = 1'b0;

    // Ring wrap across the top of the address space, DMA trickling one word at a time.
    start_layer(10'h3FC, 10'd3, 20'd5, 1'b1);
    echo_en = 1'b1;
    repeat (6) begin
      dma_wr = 1'b1; tick(1); dma_wr = 1'b0; tick(3);
    end
    wait_done(100, 1'b0);
    echo_en = 1'b0;

    // Starvation, then requests and words arriving alongside issues.
    start_layer(10'h155, 10'd15, 20'd7, 1'b1);
    pls_drv = 1'b1; tick(1); pls_drv = 1'b0;
    tick(5);
    dma_wr = 1'b1; tick(1); dma_wr = 1'b0; tick(3);
    dma_wr = 1'b1; tick(1); dma_wr = 1'b0; tick(3);
    pls_drv = 1'b1; tick(1);
    dma_wr = 1'b1; tick(4);
    pls_drv = 1'b0; dma_wr = 1'b0;
    wait_done(200, 1'b1);

    // Request overflow, cleared by restart; then word overflow.
    start_layer(10'h000, 10'd31, 20'd9, 1'b0);
    pls_drv = 1'b1; tick(5); pls_drv = 1'b0;
    tick(2);
    start_layer(10'h200, 10'd3, 20'd2, 1'b0);
    tick(1);
    dma_wr = 1'b1; tick(5); dma_wr = 1'b0;
    tick(2);
    wait_done(200, 1'b1);

    // Restart one cycle after an issue.
    start_layer(10'h080, 10'd7, 20'd9, 1'b1);
    pls_drv = 1'b1; tick(2); pls_drv = 1'b0;
    dma_wr = 1'b1; tick(1); dma_wr = 1'b0;
    n = 0;
    while (!sram_rd_en && n < 10) begin tick(1); n++; end
    chk("restart_issue_seen", sram_rd_en, 1);
    tick(1);
    start_layer(10'h080, 10'd7, 20'd9, 1'b1);
    wait_done(300, 1'b1);

    // Randomized layers with occasional restarts.
    for (int l = 0; l < 12; l++) begin
      start_layer(10'($urandom), 10'($urandom_range(0, 15)), 20'($urandom_range(0, 12)),
                  1'($urandom));
      for (int c = 0; c < 40; c++) begin
        if ($urandom_range(0, 59) == 0) begin
          start_layer(cfg_base, cfg_buf, cfg_tot, 1'($urandom));
        end else begin
          pls_drv = ($urandom_range(0, 2) == 0);
          dma_wr  = 1'($urandom);
          tick(1);
        end
      end
      pls_drv = 1'b0; dma_wr = 1'b0;
      wait_done(400, 1'b1);
    end

    tick(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
